// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Packs a valid/ready byte stream into 32-bit little-endian
//                words with lane-keep and end-of-block flags. A block ending
//                on a partial word is flushed with PAD_BYTE in unused lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,        // active-low, asynchronous assert
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_keep,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_acc_data;
    logic [3:0]       r_acc_keep;
    logic             r_acc_last;
    logic [1:0]       r_fill;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [3:0]       r_out_keep;
    logic             r_out_last;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_out_free;
    logic             w_complete;
    logic [31:0]      w_word;
    logic [3:0]       w_keep;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    // The output register can take a new word if empty or emptying this edge
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_complete = w_in_fire & ((r_fill == 2'd3) | in_last);

    // Accumulator image with the incoming byte placed and upper lanes padded
    always_comb begin
        w_word = r_acc_data;
        for (int k = 0; k < 4; k++) begin
            if (k == int'(r_fill)) begin
                w_word[8*k +: 8] = in_data;
            end else if (k > int'(r_fill)) begin
                w_word[8*k +: 8] = PAD_BYTE;
            end
        end
        case (r_fill)
            2'd0:    w_keep = 4'b0001;
            2'd1:    w_keep = 4'b0011;
            2'd2:    w_keep = 4'b0111;
            default: w_keep = 4'b1111;
        endcase
    end

    // Packing state machine, accumulator and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_FILL;
            r_acc_data  <= 32'h0;
            r_acc_keep  <= 4'h0;
            r_acc_last  <= 1'b0;
            r_fill      <= 2'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_keep  <= 4'h0;
            r_out_last  <= 1'b0;
        end else begin
            // Default: a drained word leaves the register empty unless reloaded
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_acc_data <= w_word;
                        if (w_complete) begin
                            r_fill <= 2'd0;
                            if (w_out_free) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= w_word;
                                r_out_keep  <= w_keep;
                                r_out_last  <= in_last;
                            end else begin
                                // Hold the finished word until the register frees up
                                r_acc_keep <= w_keep;
                                r_acc_last <= in_last;
                                r_state    <= ST_PEND;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_fill <= r_fill + 2'd1;
                        end
                    end
                end
                ST_PEND: begin
                    r_in_ready <= 1'b0;
                    if (w_out_fire) begin
                        // Reload on the draining edge so out_valid never bubbles
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc_data;
                        r_out_keep  <= r_acc_keep;
                        r_out_last  <= r_acc_last;
                        r_state     <= ST_FILL;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_FILL;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Count of words accepted downstream, wrapping naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (w_out_fire) begin
            r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_packer
//  Description : Directed self-checking bench for byte_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] word_cnt;

    int tests_run;
    int tests_failed;

    byte_packer #(
        .PAD_BYTE (8'h00),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted (bounded wait)
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $error("FAIL send_timeout: observed in_ready %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // ---------------- Reset state ----------------
        tick; tick;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_word_cnt",  {16'b0, word_cnt},  32'd0);
        check("rst_out_data",  out_data,           32'h0);
        rst = 1'b1;
        tick;
        check("in_ready_after_release", {31'b0, in_ready}, 32'd1);

        // ---------------- Full word ----------------
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("w1_valid", {31'b0, out_valid}, 32'd1);
        check("w1_data",  out_data,           32'h44332211);
        check("w1_keep",  {28'b0, out_keep},  32'hF);
        check("w1_last",  {31'b0, out_last},  32'd0);
        tick;
        check("w1_cnt",   {16'b0, word_cnt},  32'd1);
        check("w1_drained", {31'b0, out_valid}, 32'd0);

        // ---------------- Short block of 3 ----------------
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check("w2_data", out_data,          32'h00CCBBAA);
        check("w2_keep", {28'b0, out_keep}, 32'h7);
        check("w2_last", {31'b0, out_last}, 32'd1);
        tick;

        // ---------------- Single-byte block ----------------
        send(8'h5A, 1'b1);
        check("w3_data", out_data,          32'h0000005A);
        check("w3_keep", {28'b0, out_keep}, 32'h1);
        check("w3_last", {31'b0, out_last}, 32'd1);
        tick;
        check("w3_cnt", {16'b0, word_cnt}, 32'd3);

        // ---------------- Backpressure into PEND ----------------
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("bp_in_ready_low", {31'b0, in_ready},  32'd0);
        check("bp_held_valid",   {31'b0, out_valid}, 32'd1);
        check("bp_held_data",    out_data,           32'h04030201);
        tick;
        check("bp_stable_data",  out_data,           32'h04030201);
        check("bp_still_pend",   {31'b0, in_ready},  32'd0);
        out_ready = 1'b1;
        tick;
        check("bp_no_bubble",    {31'b0, out_valid}, 32'd1);
        check("bp_second_word",  out_data,           32'h08070605);
        check("bp_ready_back",   {31'b0, in_ready},  32'd1);
        check("bp_cnt_4",        {16'b0, word_cnt},  32'd4);
        for (int i = 9; i <= 12; i++) send(8'(i), 1'b0);
        check("bp_third_word",   out_data,           32'h0C0B0A09);
        tick;
        check("bp_cnt_6",        {16'b0, word_cnt},  32'd6);

        // ---------------- Async reset mid-word ----------------
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("ar1_word_cnt", {16'b0, word_cnt}, 32'd0);
        check("ar1_in_ready", {31'b0, in_ready}, 32'd0);
        tick;
        rst = 1'b1;
        tick;
        check("ar1_ready_first_edge", {31'b0, in_ready}, 32'd1);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        check("ar1_clean_word", out_data,          32'hA4A3A2A1);
        check("ar1_clean_keep", {28'b0, out_keep}, 32'hF);
        tick;

        // ---------------- Async reset in PEND ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0);
        check("ar2_pend", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("ar2_out_valid", {31'b0, out_valid}, 32'd0);
        check("ar2_out_data",  out_data,           32'h0);
        check("ar2_out_keep",  {28'b0, out_keep},  32'h0);
        check("ar2_out_last",  {31'b0, out_last},  32'd0);
        check("ar2_word_cnt",  {16'b0, word_cnt},  32'd0);
        check("ar2_in_ready",  {31'b0, in_ready},  32'd0);
        out_ready = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        check("ar2_ready_first_edge", {31'b0, in_ready}, 32'd1);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b1);
        check("ar2_clean_word", out_data,          32'hB4B3B2B1);
        check("ar2_clean_last", {31'b0, out_last}, 32'd1);
        tick;
        check("ar2_cnt_1", {16'b0, word_cnt}, 32'd1);

        // ---------------- word_cnt wrap ----------------
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("wrap_ready_sustained", {31'b0, in_ready}, 32'd1);
        check("wrap_cnt_ffff", {16'b0, word_cnt}, 32'h0000FFFF);
        tick;
        check("wrap_cnt_zero", {16'b0, word_cnt}, 32'h0);
        check("wrap_drained",  {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Upstream neighbour of the 32-bit word buffer stage in the BWT datapath.
- Accepts a byte stream with a valid/ready handshake and packs every 4 bytes into one 32-bit word, little-endian by arrival order.
- Presents each word on a valid/ready output with lane-keep and end-of-block flags.
- A short block (in_last on a partial word) is flushed with padding.

Parameters:
- PAD_BYTE, 8'h00, fill value for unused lanes of a flushed partial word.
- CNT_W, 16, width of the word_cnt statistic counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset: asynchronous assert, active-low (0 = reset), released synchronously by the system
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  block can accept a byte this cycle
- in_data  in  8  input byte
- in_last  in  1  final byte of the current block
- out_valid  out  1  out_data/out_keep/out_last valid
- out_ready  in  1  downstream accepts the word
- out_data  out  32  packed word
- out_keep  out  4  per-lane valid mask
- out_last  out  1  word holds the final byte of a block
- word_cnt  out  CNT_W  number of words accepted downstream since reset

Behaviour:
- Byte transfer: in_valid & in_ready at a rising edge. Word transfer: out_valid & out_ready at a rising edge.
- Lane order: the k-th byte of a word (k = 0..3) goes to out_data[8k+7:8k]. Lane 0 is the first byte received.
- Internal state:
  - Accumulator: 32-bit data, 2-bit fill count, last flag.
  - State machine FILL/PEND.
  - Output register: data, keep, last, valid.
- FILL state:
  - Each accepted byte is written to lane fill_cnt.
  - A word completes when the accepted byte has fill_cnt == 3 or in_last = 1.
  - Lanes above the final filled lane take PAD_BYTE.
  - out_keep for n bytes: 1 -> 4'b0001, 2 -> 4'b0011, 3 -> 4'b0111, 4 -> 4'b1111.
- Completion with the output register free (out_valid == 0, or a word transfer in the same cycle):
  - The word loads the output register on the same edge, so out_valid is high the cycle after the completing byte (latency 1).
  - fill_cnt resets to 0 and the state stays FILL.
- Completion with the output register occupied and not draining:
  - The word is held in the accumulator and the state goes to PEND.
  - in_ready drops on the next cycle.
- PEND state:
  - in_ready = 0.
  - On a word transfer, the held word loads the output register on that same edge (out_valid stays high, no bubble).
  - State returns to FILL and in_ready = 1 the next cycle.
- in_ready is registered: 0 during reset, 1 from the first clk edge after release, 0 exactly while in PEND.
- Throughput: one byte per cycle sustained while out_ready is held high. No bubbles are inserted on word boundaries.
- out_valid stays high, and out_data/out_keep/out_last stay stable, until the word transfer. They change only on a transfer edge or when loading into an empty register.
- in_data is ignored when in_valid = 0. in_last is only sampled on a byte transfer.
- word_cnt increments on every word transfer and wraps from all-ones to 0.
- Reset, including mid-word or in PEND:
  - Asynchronously clears out_valid, out_data (32'h0), out_keep (4'h0), out_last, word_cnt, fill_cnt, in_ready, and the state (to FILL).
  - A partially filled word is discarded.

Test Plan:
- Reset, then bytes 11,22,33,44 on consecutive cycles with out_ready = 1 -> out_data = 32'h44332211, out_keep = 4'b1111, out_last = 0, out_valid high one cycle after byte 44; word_cnt = 1.
- Bytes AA,BB,CC with in_last on CC, PAD_BYTE = 00 -> out_data = 32'h00CCBBAA, out_keep = 4'b0111, out_last = 1. Next byte starts a new word in lane 0.
- Single byte 5A with in_last -> out_data = 32'h0000005A, out_keep = 4'b0001, out_last = 1.
- Stream 12 bytes 01..0C with out_ready = 0 -> words 32'h04030201 and 32'h08070605 are held, then in_ready goes low after byte 08. Raise out_ready -> both words drain in order with no bubble, then bytes 09..0C are accepted -> 32'h0C0B0A09; word_cnt = 3.
- Assert rst low mid-word (after 2 bytes) and in PEND -> all outputs cleared immediately, without waiting for clk. After release, in_ready = 1 on the first edge and the next 4 bytes form a clean word.
- Preset traffic so 65536 words transfer -> word_cnt wraps to 16'h0000.
